// File: rtl/demux_1_8.sv
// -----------------------------------------------------------------------------
// demux_1_8
// Sequential 1-to-8 demultiplexer. Single-bit samples are routed into the
// slots of a registered 8-bit holding word, either by an internal wrapping slot
// counter (mode = 0) or by an explicit select (mode = 1). Once every slot has
// been written at least once, the word is presented with out_valid and held
// until out_ack. This reassembles words serialised one bit at a time by the
// matching 8:1 bit-select path.
//
// Parameters
//   AUTO_CLEAR : 1 = holding word cleared on acknowledge, 0 = retained.
// Ports
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   in        in   1  sample bit
//   in_valid  in   1  in carries a sample this cycle
//   mode      in   1  0 = sequential (internal counter), 1 = addressed (select)
//   select    in   3  destination slot in addressed mode
//   in_ready  out  1  block accepts a sample this cycle (registered)
//   slot      out  3  current internal slot counter
//   out       out  8  holding word
//   out_valid out  1  frame complete, out stable (registered)
//   out_ack   in   1  consumer takes the frame
// -----------------------------------------------------------------------------
module demux_1_8 #(
   parameter bit AUTO_CLEAR = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in,
   input  logic       in_valid,
   input  logic       mode,
   input  logic [2:0] select,
   output logic       in_ready,
   output logic [2:0] slot,
   output logic [7:0] out,
   output logic       out_valid,
   input  logic       out_ack
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t      state_r;
   logic [7:0]  out_r;
   logic [7:0]  mask_r;
   logic [2:0]  slot_r;
   logic        in_ready_r;
   logic        out_valid_r;

   logic        accept_s;
   logic [2:0]  target_s;
   logic [7:0]  mask_next_s;

   // Decode the accepting slot and the mask as it will look after this write.
   // accept_s uses the registered in_ready, so nothing in FULL can be taken.
   always_comb begin
      accept_s    = 1'b0;
      target_s    = 3'd0;
      mask_next_s = 8'h00;
      if (in_valid && in_ready_r) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (mode) begin
         target_s = select;
      end else begin
         target_s = slot_r;
      end
      mask_next_s = mask_r | (8'h01 << target_s);
   end

   // Frame state machine: fill slots, hold the completed word, release on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= FILL;
         out_r       <= 8'h00;
         mask_r      <= 8'h00;
         slot_r      <= 3'd0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            FILL: begin
               if (accept_s) begin
                  out_r[target_s] <= in;
                  mask_r          <= mask_next_s;
                  // Addressed writes leave the sequential run where it was.
                  if (!mode) begin
                     slot_r <= slot_r + 3'd1;
                  end else begin
                     slot_r <= slot_r;
                  end
                  if (mask_next_s == 8'hFF) begin
                     state_r     <= FULL;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else begin
                     state_r     <= FILL;
                     in_ready_r  <= 1'b1;
                     out_valid_r <= 1'b0;
                  end
               end else begin
                  // Also the path that raises in_ready on the first edge
                  // after reset release.
                  state_r     <= FILL;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            FULL: begin
               if (out_ack) begin
                  state_r     <= FILL;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
                  mask_r      <= 8'h00;
                  slot_r      <= 3'd0;
                  if (AUTO_CLEAR) begin
                     out_r <= 8'h00;
                  end else begin
                     out_r <= out_r;
                  end
               end else begin
                  state_r     <= FULL;
                  in_ready_r  <= 1'b0;
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= FILL;
               out_r       <= 8'h00;
               mask_r      <= 8'h00;
               slot_r      <= 3'd0;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign slot      = slot_r;
   assign out       = out_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_demux_1_8.sv
// -----------------------------------------------------------------------------
// tb_demux_1_8
// Drives two instances of demux_1_8 (AUTO_CLEAR = 1 and 0) with identical
// stimulus and compares them each cycle with a frame-level reference model:
// an array of slot bits, a set of written slots and a wrapping slot count.
// -----------------------------------------------------------------------------
module tb_demux_1_8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in;
   logic       in_valid;
   logic       mode;
   logic [2:0] select;
   logic       out_ack;

   logic       rdy1, rdy0, val1, val0;
   logic [2:0] slot1, slot0;
   logic [7:0] out1, out0;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit   m_ready;
   bit   m_valid;
   bit   m_full;
   int   m_slot;
   bit   m_bits1 [8];
   bit   m_bits0 [8];
   bit   m_written [8];

   always #5 clk = ~clk;

   demux_1_8 #(.AUTO_CLEAR(1'b1)) dut_ac1 (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .mode(mode),
      .select(select), .in_ready(rdy1), .slot(slot1), .out(out1),
      .out_valid(val1), .out_ack(out_ack)
   );

   demux_1_8 #(.AUTO_CLEAR(1'b0)) dut_ac0 (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .mode(mode),
      .select(select), .in_ready(rdy0), .slot(slot0), .out(out0),
      .out_valid(val0), .out_ack(out_ack)
   );

   function automatic logic [7:0] word_of(input bit b [8]);
      logic [7:0] w;
      for (int k = 0; k < 8; k++) w[k] = b[k];
      return w;
   endfunction

   function automatic logic [25:0] dut_vec();
      return {rdy1, slot1, out1, val1, rdy0, slot0, out0, val0};
   endfunction

   function automatic logic [25:0] exp_vec();
      logic [2:0] s;
      s = 3'(m_slot);
      return {m_ready, s, word_of(m_bits1), m_valid,
              m_ready, s, word_of(m_bits0), m_valid};
   endfunction

   task automatic model_reset();
      m_ready = 0; m_valid = 0; m_full = 0; m_slot = 0;
      for (int k = 0; k < 8; k++) begin
         m_bits1[k] = 0; m_bits0[k] = 0; m_written[k] = 0;
      end
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_step();
      int t, cnt;
      if (m_full) begin
         if (out_ack) begin
            m_full = 0; m_valid = 0; m_ready = 1; m_slot = 0;
            for (int k = 0; k < 8; k++) begin
               m_written[k] = 0; m_bits1[k] = 0;
            end
         end
      end else if (in_valid && m_ready) begin
         t = mode ? int'(select) : m_slot;
         m_bits1[t] = in; m_bits0[t] = in; m_written[t] = 1;
         if (!mode) m_slot = (m_slot + 1) % 8;
         cnt = 0;
         for (int k = 0; k < 8; k++) cnt += m_written[k];
         if (cnt == 8) begin
            m_full = 1; m_valid = 1; m_ready = 0;
         end else begin
            m_ready = 1;
         end
      end else begin
         m_ready = 1;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // called 1 time unit after a rising edge; pulses reset between edges
   task automatic pulse_reset();
      in_valid = 0; out_ack = 0;
      #2 rst_n = 0;
      model_reset();
      #2 rst_n = 1;
   endtask

   task automatic ack_frame();
      in_valid = 0; out_ack = 1;
      step();
      out_ack = 0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL ack_frame: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_reset();
      // disturb state first so the reset has something to clear
      mode = 0; in_valid = 1; in = 1;
      step(); step(); step();
      in_valid = 0;
      #3 rst_n = 0;
      model_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_async: got %h want %h", dut_vec(), 26'd0);
      end
      #1 rst_n = 1;
      step();
      n_cmp++;
      if (rdy1 !== 1'b1 || rdy0 !== 1'b1 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_sequential();
      logic [7:0] bits;
      bits = 8'b0100_1101;   // bits 1,0,1,1,0,0,1,0 into slots 0..7
      mode = 0; out_ack = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in = bits[i];
         n_cmp++;
         if (slot1 !== 3'(i)) begin
            n_fail++;
            $display("FAIL seq_slot%0d: got %0d want %0d", i, slot1, i);
         end
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL seq_step%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      in_valid = 0;
      n_cmp++;
      if (out1 !== 8'h4D || val1 !== 1'b1 || rdy1 !== 1'b0 || slot1 !== 3'd0) begin
         n_fail++;
         $display("FAIL seq_frame: got out=%h v=%b r=%b s=%0d want out=4d v=1 r=0 s=0",
                  out1, val1, rdy1, slot1);
      end
      ack_frame();
   endtask

   task automatic test_addressed_rewrite();
      int sels [9];
      bit vals [9];
      sels = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
      vals = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
      mode = 1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in = 1; select = 3'(7 - i);
         step();
      end
      in_valid = 0;
      n_cmp++;
      if (out1 !== 8'hFF || val1 !== 1'b1 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL addr_frame1: got %h want out=ff model %h", dut_vec(), exp_vec());
      end
      ack_frame();
      for (int i = 0; i < 9; i++) begin
         in_valid = 1; in = vals[i]; select = 3'(sels[i]);
         step();
         n_cmp++;
         if (val1 !== (i == 8) || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL addr_rewrite%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      in_valid = 0;
      n_cmp++;
      if (out1 !== 8'hF7 || out0 !== 8'hF7) begin
         n_fail++;
         $display("FAIL addr_frame2: got %h/%h want f7/f7", out1, out0);
      end
      ack_frame();
   endtask

   task automatic test_stall();
      logic [7:0] frame;
      frame = 8'($urandom);
      mode = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in = frame[i];
         step();
      end
      // producer keeps offering samples while the consumer stalls
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in = ~in; mode = 1'($urandom); select = 3'($urandom);
         step();
         n_cmp++;
         if (out1 !== frame || val1 !== 1'b1 || rdy1 !== 1'b0 || slot1 !== 3'd0
             || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall%0d: got %h want out=%h model %h", i, dut_vec(), frame, exp_vec());
         end
      end
      out_ack = 1;
      step();
      out_ack = 0; in_valid = 0;
      n_cmp++;
      if (val1 !== 1'b0 || rdy1 !== 1'b1 || out1 !== 8'h00 || out0 !== frame) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b r=%b out1=%h out0=%h want v=0 r=1 out1=00 out0=%h",
                  val1, rdy1, out1, out0, frame);
      end
   endtask

   task automatic test_midframe_reset();
      mode = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in = 1'($urandom);
         step();
      end
      pulse_reset();
      step();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in = 1;
         step();
         n_cmp++;
         if (val1 !== (i == 7) || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL midrst%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      in_valid = 0;
      n_cmp++;
      if (out1 !== 8'hFF || out0 !== 8'hFF) begin
         n_fail++;
         $display("FAIL midrst_frame: got %h/%h want ff/ff", out1, out0);
      end
      ack_frame();
   endtask

   task automatic test_mode_mix();
      mode = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in = 1;
         step();
      end
      mode = 1; select = 3'd6; in = 1;
      step();
      n_cmp++;
      if (slot1 !== 3'd4) begin
         n_fail++;
         $display("FAIL mix_slot: got %0d want 4", slot1);
      end
      mode = 0;
      for (int i = 0; i < 4; i++) begin
         in = 0;
         step();
      end
      in_valid = 0;
      n_cmp++;
      if (out1 !== 8'h0F || val1 !== 1'b1 || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL mix_frame: got %h want out=0f model %h", dut_vec(), exp_vec());
      end
      ack_frame();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in       = 1'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         mode     = 1'($urandom);
         select   = 3'($urandom);
         out_ack  = ($urandom_range(0, 2) == 0);
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      in_valid = 0; out_ack = 0;
   endtask

   initial begin
      rst_n = 0; in = 0; in_valid = 0; mode = 0; select = 3'd0; out_ack = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      step();
      test_reset();
      test_sequential();
      test_addressed_rewrite();
      test_stall();
      test_midframe_reset();
      test_mode_mix();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
